// File: rtl/rot_pkg.sv
// Shared widths, coefficient tables and saturation limits for the fine phase rotator.
package rot_pkg;

  localparam int ROT_W  = 18;
  localparam int FRAC   = 16;
  localparam int SEL_W  = 5;
  localparam int ANG_W  = 3;
  localparam int PROD_W = 2 * ROT_W;
  localparam int SUM_W  = PROD_W + 1;

  typedef logic signed [ROT_W-1:0]  sample_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [SUM_W-1:0]  sum_t;
  typedef logic [SEL_W-1:0]         sel_t;
  typedef logic [ANG_W-1:0]         angle_t;

  // cos/sin of k*11.25 deg in Q2.16, indexed by the fine angle step k
  localparam sample_t COS_TAB [8] = '{
    18'sd65536, 18'sd64277, 18'sd60547, 18'sd54491,
    18'sd46341, 18'sd36410, 18'sd25080, 18'sd12785
  };
  localparam sample_t SIN_TAB [8] = '{
    18'sd0,     18'sd12785, 18'sd25080, 18'sd36410,
    18'sd46341, 18'sd54491, 18'sd60547, 18'sd64277
  };

  // Symmetric limits keep -131072 out of the output so negation downstream is safe
  localparam sample_t SAT_MAX = 18'sd131071;
  localparam sample_t SAT_MIN = -18'sd131071;

  // Half an output LSB at the product scale, used for round-half-up
  localparam sum_t RND_HALF = sum_t'(1) <<< (FRAC - 1);

endpackage

// File: rtl/rot_if.sv
// Sample/strobe bundle between the coarse rotator and the fine rotation core.
interface rot_if;
  import rot_pkg::*;

  logic    symEn;
  logic    sym2xEn;
  sample_t i;
  sample_t q;
  sel_t    sel;
  angle_t  angle;

  logic    symEnOut;
  logic    sym2xEnOut;
  sel_t    selOut;
  sample_t iOut;
  sample_t qOut;

  // Master feeds samples in and collects rotated results
  modport master (
    output symEn, sym2xEn, i, q, sel, angle,
    input  symEnOut, sym2xEnOut, selOut, iOut, qOut
  );

  // Slave is the rotation core
  modport slave (
    input  symEn, sym2xEn, i, q, sel, angle,
    output symEnOut, sym2xEnOut, selOut, iOut, qOut
  );

endinterface

// File: rtl/rot_cmul.sv
// Registered 18x18 signed multiplier with full 36-bit product.
module rot_cmul
  import rot_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  sample_t a,
  input  sample_t b,
  output prod_t   p
);

  // Capture the full-precision product on every clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) p <= '0;
    else        p <= a * b;
  end

endmodule

// File: rtl/rot_core.sv
// Fine-angle complex rotator: rotates (i,q) CCW by angle*11.25 deg with a fixed
// two-clock latency; sel and strobes ride alongside the data untouched.
module rot_core
  import rot_pkg::*;
(
  input  logic clk,
  input  logic reset,
  rot_if.slave rot
);

  // Round half up at the output LSB, then drop the fractional bits
  function automatic sum_t roundShift(input sum_t x);
    return (x + RND_HALF) >>> FRAC;
  endfunction

  // Clamp into the symmetric output range
  function automatic sample_t saturate(input sum_t x);
    if (x > sum_t'(SAT_MAX))      return SAT_MAX;
    else if (x < sum_t'(SAT_MIN)) return SAT_MIN;
    else                          return x[ROT_W-1:0];
  endfunction

  sample_t cosK_p0;
  sample_t sinK_p0;

  assign cosK_p0 = COS_TAB[rot.angle];
  assign sinK_p0 = SIN_TAB[rot.angle];

  // ---- stage 1: products and side-band delay ----
  prod_t prodIC_p1;
  prod_t prodQS_p1;
  prod_t prodIS_p1;
  prod_t prodQC_p1;
  sel_t  sel_p1;
  logic  symEn_p1;
  logic  sym2xEn_p1;

  rot_cmul uMulIC (.clk(clk), .reset(reset), .a(rot.i), .b(cosK_p0), .p(prodIC_p1));
  rot_cmul uMulQS (.clk(clk), .reset(reset), .a(rot.q), .b(sinK_p0), .p(prodQS_p1));
  rot_cmul uMulIS (.clk(clk), .reset(reset), .a(rot.i), .b(sinK_p0), .p(prodIS_p1));
  rot_cmul uMulQC (.clk(clk), .reset(reset), .a(rot.q), .b(cosK_p0), .p(prodQC_p1));

  // Delay sel and strobes to match the multiplier register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_p1     <= '0;
      symEn_p1   <= 1'b0;
      sym2xEn_p1 <= 1'b0;
    end else begin
      sel_p1     <= rot.sel;
      symEn_p1   <= rot.symEn;
      sym2xEn_p1 <= rot.sym2xEn;
    end
  end

  sum_t sumI_p1;
  sum_t sumQ_p1;

  assign sumI_p1 = sum_t'(prodIC_p1) - sum_t'(prodQS_p1);
  assign sumQ_p1 = sum_t'(prodIS_p1) + sum_t'(prodQC_p1);

  // ---- stage 2: combine, round, saturate, output register ----
  sample_t iOut_p2;
  sample_t qOut_p2;
  sel_t    sel_p2;
  logic    symEn_p2;
  logic    sym2xEn_p2;

  // Register rotated samples together with the delayed side-band
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iOut_p2    <= '0;
      qOut_p2    <= '0;
      sel_p2     <= '0;
      symEn_p2   <= 1'b0;
      sym2xEn_p2 <= 1'b0;
    end else begin
      iOut_p2    <= saturate(roundShift(sumI_p1));
      qOut_p2    <= saturate(roundShift(sumQ_p1));
      sel_p2     <= sel_p1;
      symEn_p2   <= symEn_p1;
      sym2xEn_p2 <= sym2xEn_p1;
    end
  end

  assign rot.iOut       = iOut_p2;
  assign rot.qOut       = qOut_p2;
  assign rot.selOut     = sel_p2;
  assign rot.symEnOut   = symEn_p2;
  assign rot.sym2xEnOut = sym2xEn_p2;

endmodule

// File: tb/tb_rot_core.sv
// Directed bench for rot_core: hand-computed rotations, saturation, rounding,
// pipeline alignment of sel/strobes and asynchronous reset flush.
module tb_rot_core;
  import rot_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  rot_if bus ();

  rot_core dut (
    .clk   (clk),
    .reset (reset),
    .rot   (bus)
  );

  task automatic checkOut(input string tag, input sample_t eI, input sample_t eQ,
                          input sel_t eSel, input logic eSym, input logic eSym2);
    vectors++;
    assert (bus.iOut === eI) else begin
      miscompares++;
      $error("FAIL %s iOut got %0d expected %0d", tag, bus.iOut, eI);
    end
    vectors++;
    assert (bus.qOut === eQ) else begin
      miscompares++;
      $error("FAIL %s qOut got %0d expected %0d", tag, bus.qOut, eQ);
    end
    vectors++;
    assert ({bus.selOut, bus.symEnOut, bus.sym2xEnOut} === {eSel, eSym, eSym2}) else begin
      miscompares++;
      $error("FAIL %s sel/symEn/sym2xEn got %0d/%0b/%0b expected %0d/%0b/%0b", tag,
             bus.selOut, bus.symEnOut, bus.sym2xEnOut, eSel, eSym, eSym2);
    end
  endtask

  task automatic drive(input angle_t a, input sample_t ii, input sample_t qq,
                       input sel_t s, input logic se, input logic s2);
    bus.angle   = a;
    bus.i       = ii;
    bus.q       = qq;
    bus.sel     = s;
    bus.symEn   = se;
    bus.sym2xEn = s2;
  endtask

  // One clock: check what emerged from the sample driven two calls ago, then drive the next
  task automatic cyc(input string tag,
                     input angle_t a, input sample_t ii, input sample_t qq,
                     input sel_t s, input logic se, input logic s2,
                     input sample_t eI, input sample_t eQ,
                     input sel_t eSel, input logic eSym, input logic eSym2);
    @(negedge clk);
    checkOut(tag, eI, eQ, eSel, eSym, eSym2);
    drive(a, ii, qq, s, se, s2);
  endtask

  initial begin
    // Reset held with live inputs: everything must stay cleared
    drive(3'd0, 18'sd65536, 18'sd0, 5'd21, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    checkOut("reset", 18'sd0, 18'sd0, 5'd0, 1'b0, 1'b0);

    @(negedge clk);
    reset = 1'b1;
    drive(3'd0, 18'sd0, 18'sd0, 5'd0, 1'b0, 1'b0);

    // Back-to-back stream; each call expects the sample from two calls earlier
    cyc("post_rel0",   3'd0, 18'sd65536,   18'sd0,       5'd21, 1'b1, 1'b0,
        18'sd0, 18'sd0, 5'd0, 1'b0, 1'b0);
    cyc("post_rel1",   3'd4, 18'sd65536,   18'sd0,       5'd0,  1'b0, 1'b1,
        18'sd0, 18'sd0, 5'd0, 1'b0, 1'b0);
    cyc("a0_unit",     3'd2, 18'sd0,       18'sd65536,   5'd3,  1'b0, 1'b0,
        18'sd65536, 18'sd0, 5'd21, 1'b1, 1'b0);
    cyc("a4_unit",     3'd4, 18'sd131071,  18'sd131071,  5'd31, 1'b1, 1'b1,
        18'sd46341, 18'sd46341, 5'd0, 1'b0, 1'b1);
    cyc("a2_q",        3'd0, -18'sd131072, 18'sd0,       5'd0,  1'b0, 1'b0,
        -18'sd25080, 18'sd60547, 5'd3, 1'b0, 1'b0);
    cyc("a4_sat_pos",  3'd4, -18'sd131072, -18'sd131072, 5'd1,  1'b0, 1'b0,
        18'sd0, 18'sd131071, 5'd31, 1'b1, 1'b1);
    cyc("a0_sat_neg",  3'd1, 18'sd65536,   18'sd0,       5'd5,  1'b1, 1'b0,
        -18'sd131071, 18'sd0, 5'd0, 1'b0, 1'b0);
    cyc("a4_sat_neg",  3'd3, 18'sd0,       18'sd65536,   5'd10, 1'b0, 1'b1,
        18'sd0, -18'sd131071, 5'd1, 1'b0, 1'b0);
    cyc("a1_unit",     3'd7, 18'sd65536,   18'sd65536,   5'd7,  1'b1, 1'b1,
        18'sd64277, 18'sd12785, 5'd5, 1'b1, 1'b0);
    cyc("a3_q",        3'd4, 18'sd1,       18'sd0,       5'd12, 1'b0, 1'b0,
        -18'sd36410, 18'sd54491, 5'd10, 1'b0, 1'b1);
    cyc("a7_iq",       3'd4, -18'sd1,      18'sd0,       5'd13, 1'b0, 1'b0,
        -18'sd51492, 18'sd77062, 5'd7, 1'b1, 1'b1);
    cyc("rnd_pos",     3'd5, -18'sd65536,  18'sd0,       5'd30, 1'b0, 1'b1,
        18'sd1, 18'sd1, 5'd12, 1'b0, 1'b0);
    cyc("rnd_neg",     3'd0, 18'sd0,       18'sd0,       5'd0,  1'b0, 1'b0,
        -18'sd1, -18'sd1, 5'd13, 1'b0, 1'b0);
    cyc("a5_neg",      3'd0, 18'sd65536,   18'sd0,       5'd9,  1'b1, 1'b1,
        -18'sd36410, -18'sd54491, 5'd30, 1'b0, 1'b1);
    cyc("idle",        3'd0, 18'sd0,       18'sd0,       5'd0,  1'b0, 1'b0,
        18'sd0, 18'sd0, 5'd0, 1'b0, 1'b0);

    // Mid-stream reset: outputs must clear between clock edges
    @(negedge clk);
    checkOut("pre_rst", 18'sd65536, 18'sd0, 5'd9, 1'b1, 1'b1);
    drive(3'd0, 18'sd65536, 18'sd65536, 5'd9, 1'b1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkOut("rst_async", 18'sd0, 18'sd0, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOut("rst_held", 18'sd0, 18'sd0, 5'd0, 1'b0, 1'b0);

    // Release with a sample already presented; it emerges two clocks later
    @(negedge clk);
    reset = 1'b1;
    drive(3'd6, 18'sd65536, 18'sd0, 5'd17, 1'b1, 1'b0);
    cyc("rel_flush",   3'd2, 18'sd65536,   18'sd0,       5'd2,  1'b0, 1'b1,
        18'sd0, 18'sd0, 5'd0, 1'b0, 1'b0);
    cyc("rel_first",   3'd0, 18'sd0,       18'sd0,       5'd0,  1'b0, 1'b0,
        18'sd25080, 18'sd60547, 5'd17, 1'b1, 1'b0);
    cyc("rel_second",  3'd0, 18'sd0,       18'sd0,       5'd0,  1'b0, 1'b0,
        18'sd60547, 18'sd25080, 5'd2, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
